// File: rtl/xgmii_tx_sched.sv
// xgmii_tx_sched: frame scheduler for the XGMII TX generator with ARP priority, gap pacing, watchdog and per-second stats.
module xgmii_tx_sched #(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518,
  parameter int ARP_LEN = 64,
  parameter int TIMEOUT = 4096
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        sec_tick,
  input  logic        tx_enable,
  input  logic        tx_req_arp,
  input  logic [15:0] tx_frame_len,
  input  logic [31:0] tx_inter_frame_gap,
  output logic        gen_start,
  output logic        gen_sel,
  output logic [15:0] gen_len,
  input  logic        gen_done,
  output logic [31:0] tx_pps,
  output logic [31:0] tx_throughput,
  output logic        tx_busy,
  output logic        tx_timeout
);
  typedef enum logic [1:0] {IDLE, START, WAIT_DONE, GAP} state_t;
  state_t state, state_nx;
  logic arp_q, arp_pending, sel_r;
  logic [15:0] wd, meas_len;
  logic [31:0] gap_cnt, frame_cnt, byte_cnt, frame_inc, byte_inc;
  logic [32:0] byte_sum;
  logic rise, eligible, done, abort, expire, launch, launch_sel, count;
  // the last gap cycle doubles as START so the strobe lands G+1 cycles after gen_done
  always_comb begin
    rise = tx_req_arp & ~arp_q;
    eligible = arp_pending | tx_enable;
    done = state == WAIT_DONE && gen_done;
    abort = state == WAIT_DONE && !gen_done && wd + 16'd1 == 16'(TIMEOUT);
    expire = state == GAP && gap_cnt == 32'd1;
    launch = state == START || (expire && eligible);
    launch_sel = state == START ? sel_r : arp_pending;
    meas_len = tx_frame_len < 16'(MIN_LEN) ? 16'(MIN_LEN) : tx_frame_len > 16'(MAX_LEN) ? 16'(MAX_LEN) : tx_frame_len;
    count = done && !gen_sel;
    frame_inc = count && frame_cnt != '1 ? frame_cnt + 32'd1 : frame_cnt;
    byte_sum = {1'b0, byte_cnt} + {17'd0, gen_len};
    byte_inc = !count ? byte_cnt : byte_sum[32] ? '1 : byte_sum[31:0];
    state_nx = state == IDLE ? (eligible ? START : IDLE)
             : state == START ? WAIT_DONE
             : state == WAIT_DONE ? (done || abort ? GAP : WAIT_DONE)
             : expire ? (eligible ? WAIT_DONE : IDLE) : GAP;
  end
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state <= IDLE;
      gen_start <= 1'b0;
      gen_sel <= 1'b0;
      gen_len <= '0;
      tx_pps <= '0;
      tx_throughput <= '0;
      tx_busy <= 1'b0;
      tx_timeout <= 1'b0;
      arp_q <= 1'b0;
      arp_pending <= 1'b0;
      sel_r <= 1'b0;
      wd <= '0;
      gap_cnt <= '0;
      frame_cnt <= '0;
      byte_cnt <= '0;
    end else begin
      state <= state_nx;
      tx_busy <= state_nx != IDLE;
      gen_start <= launch;
      arp_q <= tx_req_arp;
      arp_pending <= rise | (arp_pending & ~(launch & launch_sel));
      if (state == IDLE) sel_r <= arp_pending;
      if (launch) begin
        gen_sel <= launch_sel;
        gen_len <= launch_sel ? 16'(ARP_LEN) : meas_len;
      end
      wd <= state == WAIT_DONE ? wd + 16'd1 : 16'd0;
      if (state_nx == GAP && state != GAP) gap_cnt <= tx_inter_frame_gap == '0 ? 32'd1 : tx_inter_frame_gap;
      else if (state == GAP) gap_cnt <= gap_cnt - 32'd1;
      if (abort) tx_timeout <= 1'b1;
      if (sec_tick) begin
        tx_pps <= frame_inc;
        tx_throughput <= byte_inc;
        frame_cnt <= '0;
        byte_cnt <= '0;
      end else begin
        frame_cnt <= frame_inc;
        byte_cnt <= byte_inc;
      end
    end
  end
endmodule

// File: tb/tb_xgmii_tx_sched.sv
// tb_xgmii_tx_sched: timeline-based reference model with per-cycle compare, directed pacing/priority/latch/timeout scenarios and random traffic.
module tb_xgmii_tx_sched;
  localparam int MINL = 64, MAXL = 1518, ARPL = 64, TMO = 4096;
  logic sys_clk = 1'b0, sys_rst = 1'b1, sec_tick = 1'b0, tx_enable = 1'b0, tx_req_arp = 1'b0, gen_done = 1'b0;
  logic [15:0] tx_frame_len = 16'd64;
  logic [31:0] tx_inter_frame_gap = 32'd10;
  logic gen_start, gen_sel, tx_busy, tx_timeout;
  logic [15:0] gen_len;
  logic [31:0] tx_pps, tx_throughput;
  int total = 0, passed = 0, cyc = 0;
  int sq_cyc[$], sq_sel[$], sq_len[$];
  int lens [9] = '{0, 20, 63, 64, 65, 1517, 1518, 1519, 9000};
  int lat = 8, gcnt = 0, withhold_n = 0;
  bit noise = 0, rand_tick = 0, rand_lat = 0, tick_on_done = 0, tick_req = 0;

  xgmii_tx_sched dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .sec_tick(sec_tick), .tx_enable(tx_enable),
    .tx_req_arp(tx_req_arp), .tx_frame_len(tx_frame_len), .tx_inter_frame_gap(tx_inter_frame_gap),
    .gen_start(gen_start), .gen_sel(gen_sel), .gen_len(gen_len), .gen_done(gen_done),
    .tx_pps(tx_pps), .tx_throughput(tx_throughput), .tx_busy(tx_busy), .tx_timeout(tx_timeout)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic void chk(string name, longint act, longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endfunction

  function automatic int scyc(int i);
    return (i >= 0 && i < sq_cyc.size()) ? sq_cyc[i] : -1000000;
  endfunction
  function automatic int ssel(int i);
    return (i >= 0 && i < sq_sel.size()) ? sq_sel[i] : -1;
  endfunction
  function automatic int slen(int i);
    return (i >= 0 && i < sq_len.size()) ? sq_len[i] : -1;
  endfunction
  function automatic int count_sel(int base, int sel);
    int n = 0;
    for (int i = base; i < sq_sel.size(); i++) if (sq_sel[i] == sel) n++;
    return n;
  endfunction
  function automatic logic [15:0] clamp(logic [15:0] v);
    return v < MINL ? 16'(MINL) : v > MAXL ? 16'(MAXL) : v;
  endfunction

  // reference model: frames, gaps and a pending launch are tracked as absolute cycle numbers
  bit m_req_q, m_arp, m_in_frame, m_dec, m_dec_sel;
  int m_t0, m_gap_last;
  longint m_frames, m_bytes;
  logic e_start, e_sel, e_busy, e_to;
  logic [15:0] e_len;
  logic [31:0] e_pps, e_thr;
  always @(posedge sys_clk) begin : model
    bit rise, elig, clr, launch;
    int g;
    if (sys_rst) begin
      m_req_q = 0; m_arp = 0; m_in_frame = 0; m_dec = 0; m_dec_sel = 0; m_gap_last = -1; m_t0 = 0;
      m_frames = 0; m_bytes = 0;
      e_start = 0; e_sel = 0; e_len = 0; e_busy = 0; e_to = 0; e_pps = 0; e_thr = 0;
    end else begin
      rise = tx_req_arp && !m_req_q;
      elig = m_arp || tx_enable;
      g = tx_inter_frame_gap == 0 ? 1 : int'(tx_inter_frame_gap);
      e_start = 0; clr = 0; launch = 0;
      if (m_in_frame) begin
        if (gen_done || cyc == m_t0 + TMO - 1) begin
          if (!gen_done) e_to = 1;
          else if (!e_sel) begin m_frames++; m_bytes += e_len; end
          m_in_frame = 0;
          m_gap_last = cyc + g;
        end
      end else if (m_gap_last == cyc) begin
        m_gap_last = -1;
        if (elig) begin launch = 1; e_sel = m_arp; end
      end else if (m_dec) begin
        m_dec = 0; launch = 1; e_sel = m_dec_sel;
      end else if (m_gap_last < 0 && elig) begin
        m_dec = 1; m_dec_sel = m_arp;
      end
      if (launch) begin
        e_start = 1; e_len = e_sel ? 16'(ARPL) : clamp(tx_frame_len); clr = e_sel; m_in_frame = 1; m_t0 = cyc + 1;
      end
      if (sec_tick) begin
        e_pps = m_frames > 64'hFFFFFFFF ? 32'hFFFFFFFF : m_frames[31:0];
        e_thr = m_bytes > 64'hFFFFFFFF ? 32'hFFFFFFFF : m_bytes[31:0];
        m_frames = 0; m_bytes = 0;
      end
      m_arp = rise || (m_arp && !clr);
      m_req_q = tx_req_arp;
      e_busy = m_in_frame || m_gap_last >= 0 || m_dec;
    end
    cyc++;
  end

  always @(negedge sys_clk) if (cyc > 0) begin
    chk("gen_start", gen_start, e_start);
    chk("gen_sel", gen_sel, e_sel);
    chk("gen_len", gen_len, e_len);
    chk("tx_busy", tx_busy, e_busy);
    chk("tx_timeout", tx_timeout, e_to);
    chk("tx_pps", tx_pps, e_pps);
    chk("tx_throughput", tx_throughput, e_thr);
    if (gen_start) begin sq_cyc.push_back(cyc); sq_sel.push_back(int'(gen_sel)); sq_len.push_back(int'(gen_len)); end
  end

  // frame generator stand-in, also owner of sec_tick
  always @(negedge sys_clk) begin
    gen_done = 0;
    if (sys_rst) gcnt = 0;
    else begin
      if (gcnt > 0) begin gcnt--; if (gcnt == 0) gen_done = 1; end
      if (gen_start) begin
        if (withhold_n > 0) withhold_n--;
        else gcnt = rand_lat ? $urandom_range(1, 20) : lat;
      end
      if (noise && $urandom_range(0, 40) == 0) gen_done = 1;
    end
    sec_tick = tick_req || (gen_done && tick_on_done) || (rand_tick && $urandom_range(0, 150) == 0);
    if (gen_done && tick_on_done) tick_on_done = 0;
    tick_req = 0;
  end

  task automatic wait_strobes(input int n);
    int g = 0;
    while (sq_cyc.size() < n && g < 20000) begin @(negedge sys_clk); g++; end
    if (sq_cyc.size() < n) chk("strobe_wait", sq_cyc.size(), n);
  endtask

  task automatic wait_idle();
    int g = 0;
    while (tx_busy && g < 500) begin @(negedge sys_clk); g++; end
    if (tx_busy) chk("idle_wait", tx_busy, 0);
  endtask

  initial begin
    int t0, n, m, s, g, k;
    bit arp_done;
    repeat (3) @(negedge sys_clk);
    chk("rst_busy", tx_busy, 0);
    chk("rst_start", gen_start, 0);
    chk("rst_len", gen_len, 0);
    sys_rst = 0;
    @(negedge sys_clk);
    t0 = cyc;
    tx_enable = 1;
    wait_strobes(4);
    chk("start_latency", scyc(0) - t0, 2);
    chk("period_a", scyc(1) - scyc(0), 19);
    chk("period_b", scyc(3) - scyc(2), 19);
    chk("pace_sel", ssel(3), 0);
    chk("pace_len", slen(3), 64);
    n = sq_cyc.size();
    @(negedge sys_clk) tx_req_arp = 1;
    @(negedge sys_clk) tx_req_arp = 0;
    wait_strobes(n + 2);
    chk("arp_sel", ssel(n), 1);
    chk("arp_len", slen(n), 64);
    chk("arp_spacing", scyc(n) - scyc(n - 1), 19);
    chk("post_arp_sel", ssel(n + 1), 0);
    tx_frame_len = 16'd20;
    n = sq_cyc.size();
    wait_strobes(n + 2);
    chk("clamp_lo", slen(n + 1), 64);
    tx_frame_len = 16'd9000;
    n = sq_cyc.size();
    wait_strobes(n + 2);
    chk("clamp_hi", slen(n + 1), 1518);
    tx_inter_frame_gap = 0;
    n = sq_cyc.size();
    wait_strobes(n + 3);
    chk("gap_zero_period", scyc(n + 2) - scyc(n + 1), 10);
    n = sq_cyc.size();
    wait_strobes(n + 1);
    tx_enable = 0;
    m = sq_cyc.size();
    wait_idle();
    repeat (40) @(negedge sys_clk);
    chk("drop_busy", tx_busy, 0);
    chk("drop_no_start", sq_cyc.size(), m);
    tick_req = 1;
    repeat (3) @(negedge sys_clk);
    tx_frame_len = 16'd100;
    tx_inter_frame_gap = 3;
    n = sq_cyc.size();
    arp_done = 0;
    tx_enable = 1;
    g = 0;
    while (count_sel(n, 0) < 5 && g < 3000) begin
      @(negedge sys_clk);
      g++;
      if (!arp_done && count_sel(n, 0) >= 2) begin tx_req_arp = 1; arp_done = 1; end
      else tx_req_arp = 0;
    end
    tx_enable = 0;
    tx_req_arp = 0;
    tick_on_done = 1;
    if (count_sel(n, 0) < 5) chk("five_frames", count_sel(n, 0), 5);
    wait_idle();
    repeat (2) @(negedge sys_clk);
    chk("pps_five", tx_pps, 5);
    chk("thr_500", tx_throughput, 500);
    chk("arp_in_run", count_sel(n, 1), 1);
    tick_req = 1;
    repeat (3) @(negedge sys_clk);
    chk("pps_restart", tx_pps, 0);
    chk("thr_restart", tx_throughput, 0);
    withhold_n = 1;
    tx_frame_len = 16'd64;
    tx_inter_frame_gap = 5;
    n = sq_cyc.size();
    tx_enable = 1;
    wait_strobes(n + 1);
    s = scyc(n);
    g = 0;
    while (!tx_timeout && g < 5000) begin @(negedge sys_clk); g++; end
    chk("timeout_at", cyc - s, TMO);
    wait_strobes(n + 2);
    chk("after_timeout", scyc(n + 1) - s, TMO + 5);
    @(negedge sys_clk) sys_rst = 1;
    @(negedge sys_clk);
    chk("mid_rst_start", gen_start, 0);
    chk("mid_rst_sel", gen_sel, 0);
    chk("mid_rst_len", gen_len, 0);
    chk("mid_rst_busy", tx_busy, 0);
    chk("mid_rst_timeout", tx_timeout, 0);
    chk("mid_rst_pps", tx_pps, 0);
    chk("mid_rst_thr", tx_throughput, 0);
    tx_enable = 0;
    @(negedge sys_clk) sys_rst = 0;
    rand_lat = 1; noise = 1; rand_tick = 1;
    for (int i = 0; i < 6000; i++) begin
      @(negedge sys_clk);
      sys_rst = $urandom_range(0, 1499) == 0;
      if ($urandom_range(0, 59) == 0) tx_enable = ~tx_enable;
      if ($urandom_range(0, 29) == 0) tx_req_arp = ~tx_req_arp;
      if ($urandom_range(0, 39) == 0) begin
        k = $urandom_range(0, 9);
        tx_frame_len = k < 9 ? 16'(lens[k]) : 16'($urandom);
      end
      if ($urandom_range(0, 49) == 0) tx_inter_frame_gap = $urandom_range(0, 12);
    end
    sys_rst = 0; tx_enable = 0; tx_req_arp = 0; noise = 0; rand_tick = 0;
    repeat (100) @(negedge sys_clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
